// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration slice: FSM encoding and launch timeout default.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2
  } state_e;

  localparam logic [15:0] TmoDefault = 16'd50000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant from the highest-priority pending request,
// plus the pointer value to register (one past the winner when advancing).
module rr_arbiter #(
  parameter int unsigned NReq = 4
) (
  input  logic [NReq-1:0] req,
  input  logic [2:0]      ptr,
  input  logic            advance,
  output logic [NReq-1:0] gnt,
  output logic [2:0]      ptr_nxt
);

  logic [7:0] req_ext;
  logic [7:0] gnt_ext;
  logic [2:0] idx;
  logic [2:0] win;
  logic       found;

  assign req_ext = 8'(req);

  always_comb begin
    gnt_ext = '0;
    win     = '0;
    found   = 1'b0;
    idx     = '0;
    // Scan starting at ptr, wrapping modulo NReq; first pending request wins.
    for (int unsigned k = 0; k < NReq; k++) begin
      idx = 3'((32'(ptr) + k) % NReq);
      if (!found && req_ext[idx]) begin
        found        = 1'b1;
        gnt_ext[idx] = 1'b1;
        win          = idx;
      end
    end
    ptr_nxt = ptr;
    if (advance && found) begin
      ptr_nxt = (win == 3'(NReq - 1)) ? 3'd0 : win + 3'd1;
    end
  end

  assign gnt = gnt_ext[NReq-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a UART TX datapath: grants one requester per frame,
// launches it with tx_en and abandons the byte if the datapath never responds.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter logic [15:0] TMO   = TmoDefault
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic [2:0]         grant_id,
  output logic               active,
  output logic               err_tmo
);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_nxt;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic        tx_en_q, tx_en_d;
  logic        err_tmo_q, err_tmo_d;

  logic [N_REQ-1:0] gnt;
  logic [2:0]       win_idx;
  logic [7:0]       win_byte;
  logic             idle;

  assign idle = (state_q == StIdle);

  rr_arbiter #(
    .NReq(N_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .advance (idle),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  always_comb begin
    win_idx  = '0;
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = 3'(i);
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    err_tmo_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          state_d    = StLaunch;
          cnt_d      = '0;
          tx_data_d  = win_byte;
          grant_id_d = win_idx;
        end
      end
      StLaunch: begin
        cnt_d = cnt_q + 16'd1;
        if (tx_done) begin
          state_d = StIdle;
        end else if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == TMO - 16'd1) begin
          state_d   = StIdle;
          err_tmo_d = 1'b1;
        end
      end
      StWaitDone: begin
        // A falling tx_busy alone is not an end-of-frame; only tx_done releases the owner.
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    tx_en_d = (state_d == StLaunch);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      tx_en_q    <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_nxt;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      tx_en_q    <= tx_en_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  // Gating with arst keeps the strobe low throughout reset, not just after the first edge.
  assign req_ready = (idle && arst) ? gnt : '0;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign active    = !idle;
  assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed frame table, reset corner cases and
// randomized frames checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int          N    = 4;
  localparam logic [15:0] TMOV = 16'd8;

  logic          clk;
  logic          arst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [2:0]    grant_id;
  logic          active;
  logic          err_tmo;

  uart_tx_arbiter #(
    .N_REQ(N),
    .TMO  (TMOV)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .active   (active),
    .err_tmo  (err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int last_grant = N - 1;  // model: requester granted most recently

  // Frame modes: 0 = busy then done, 1 = short frame (done in launch), 2 = timeout.
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          mode;
    int          k;
    int          m;
    logic [3:0]  exp_rdy;
    logic [7:0]  exp_byte;
    logic [2:0]  exp_id;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] valid, input int last);
    for (int o = 1; o <= N; o++) begin
      if (valid[(last + o) % N]) return (last + o) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [3:0] valid, input logic [31:0] data, input int mode,
                          input int k, input int m, input logic [3:0] exp_rdy,
                          input logic [7:0] exp_byte, input logic [2:0] exp_id);
    logic hit;
    req_valid = valid;
    req_data  = data;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    @(negedge clk);
    chk("idle_ready", req_ready, exp_rdy);
    chk("idle_active", active, 0);
    chk("idle_txen", tx_en, 0);
    chk("idle_err", err_tmo, 0);
    step();
    for (int c = 0; c < int'(TMOV); c++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      hit       = (mode != 2) && (c == k);
      tx_busy   = hit && (mode == 0);
      tx_done   = hit && (mode == 1);
      @(negedge clk);
      chk("launch_txen", tx_en, 1);
      chk("launch_data", tx_data, exp_byte);
      chk("launch_id", grant_id, exp_id);
      chk("launch_ready", req_ready, 0);
      chk("launch_active", active, 1);
      chk("launch_err", err_tmo, 0);
      step();
      if (hit) break;
    end
    tx_busy = 1'b0;
    tx_done = 1'b0;
    if (mode == 0) begin
      for (int j = 0; j <= m; j++) begin
        req_valid = 4'($urandom);
        req_data  = $urandom;
        tx_busy   = 1'($urandom_range(0, 1));
        tx_done   = (j == m);
        @(negedge clk);
        chk("wait_txen", tx_en, 0);
        chk("wait_active", active, 1);
        chk("wait_data", tx_data, exp_byte);
        chk("wait_id", grant_id, exp_id);
        chk("wait_ready", req_ready, 0);
        step();
      end
      tx_busy = 1'b0;
      tx_done = 1'b0;
    end
    req_valid = '0;
    @(negedge clk);
    chk("end_active", active, 0);
    chk("end_txen", tx_en, 0);
    chk("end_err", err_tmo, (mode == 2) ? 1 : 0);
    chk("end_data", tx_data, exp_byte);
    step();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b1111, 32'h44332211, 0, 1, 2, 4'b0001, 8'h11, 3'd0};
    vecs[1] = '{4'b1111, 32'h44332211, 0, 0, 0, 4'b0010, 8'h22, 3'd1};
    vecs[2] = '{4'b1111, 32'h44332211, 1, 3, 0, 4'b0100, 8'h33, 3'd2};
    vecs[3] = '{4'b1111, 32'h44332211, 0, 7, 1, 4'b1000, 8'h44, 3'd3};
    vecs[4] = '{4'b0001, 32'h000000A5, 0, 2, 3, 4'b0001, 8'hA5, 3'd0};
    vecs[5] = '{4'b0100, 32'h00C70000, 0, 1, 0, 4'b0100, 8'hC7, 3'd2};
    vecs[6] = '{4'b0101, 32'h00660055, 1, 0, 0, 4'b0001, 8'h55, 3'd0};
    vecs[7] = '{4'b0010, 32'h0000EE00, 2, 0, 0, 4'b0010, 8'hEE, 3'd1};
    vecs[8] = '{4'b1010, 32'h3C001200, 0, 4, 2, 4'b1000, 8'h3C, 3'd3};
    vecs[9] = '{4'b0110, 32'h00998800, 1, 5, 0, 4'b0010, 8'h88, 3'd1};

    arst      = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_txen", tx_en, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err_tmo, 0);
    step();
    step();
    chk("rst_hold_active", active, 0);
    req_valid = '0;
    arst      = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      do_frame(vecs[i].valid, vecs[i].data, vecs[i].mode, vecs[i].k, vecs[i].m,
               vecs[i].exp_rdy, vecs[i].exp_byte, vecs[i].exp_id);
      last_grant = int'(vecs[i].exp_id);
    end

    // Reset while the frame sits in WAIT_DONE.
    begin
      int w;
      w = rr_pick(4'b0100, last_grant);
      do_frame(4'b0100, 32'h00770000, 1, 0, 0, 4'(1 << w), 8'h77, 3'(w));
      last_grant = w;
      req_valid = 4'b1000;
      req_data  = 32'h5A000000;
      @(negedge clk);
      chk("mr_ready", req_ready, 4'b1000);
      step();
      req_valid = 4'b1111;
      tx_busy   = 1'b1;
      step();
      @(negedge clk);
      chk("mr_wait_active", active, 1);
      chk("mr_wait_data", tx_data, 8'h5A);
      step();
      arst = 1'b0;
      #1;
      chk("mr_txen", tx_en, 0);
      chk("mr_data", tx_data, 0);
      chk("mr_id", grant_id, 0);
      chk("mr_active", active, 0);
      chk("mr_err", err_tmo, 0);
      chk("mr_ready0", req_ready, 0);
      step();
      chk("mr_err_hold", err_tmo, 0);
      tx_busy = 1'b0;
      arst    = 1'b1;
      last_grant = N - 1;
      do_frame(4'b1111, 32'h04030201, 0, 0, 0, 4'b0001, 8'h01, 3'd0);
      last_grant = 0;
    end

    for (int r = 0; r < 60; r++) begin
      logic [3:0]  v;
      logic [31:0] d;
      int w, mode, k;
      v = 4'($urandom_range(1, 15));
      d = $urandom;
      w = rr_pick(v, last_grant);
      mode = $urandom_range(0, 2);
      k = $urandom_range(0, int'(TMOV) - 1);
      do_frame(v, d, mode, k, $urandom_range(0, 5), 4'(1 << w), d[8*w +: 8], 3'(w));
      last_grant = w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
